// File: rtl/cpu_core_pkg.sv
// Shared types for the cpu core: fetch FSM state and fetch buffer entry.
package cpu_core_pkg;

   typedef enum logic [1:0] {
      FS_BOOT,
      FS_RUN,
      FS_DRAIN
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        redirect;
   } fetch_entry_t;

endpackage

// File: rtl/cpu_core_macros.svh
// Core-wide constants shared by the pipeline stages.
`ifndef CPU_CORE_MACROS_SVH
`define CPU_CORE_MACROS_SVH
`define PC_INIT      32'h0000_0000
`define NOP_INSTRUCT 32'h0000_0013
`endif

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of fetched instructions; clear beats push, head is read from registered storage.
module fetch_buffer
   import cpu_core_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic                         clock_i,
   input  logic                         nreset_i,
   input  logic                         i_push,
   input  fetch_entry_t                 i_entry,
   input  logic                         i_pop,
   input  logic                         i_clear,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic                         o_empty,
   output fetch_entry_t                 o_head
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t  r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_do_push;
   logic          w_do_pop;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign w_do_push = i_push & (r_count != CW'(DEPTH));
   assign w_do_pop  = i_pop & (r_count != '0);

   always_ff @(posedge clock_i or negedge nreset_i) begin
      if (!nreset_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= ptr_next(r_wr_ptr);
         if (w_do_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
         r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      end
   end

   always_ff @(posedge clock_i) begin
      if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_entry;
   end

   assign o_count = r_count;
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, memory request/response tracking, and the decode-side output.
`include "cpu_core_macros.svh"
module fetch_unit
   import cpu_core_pkg::*;
#(
   parameter logic [31:0] PC_INIT = `PC_INIT,
   parameter int          DEPTH   = 4
)(
   input  logic        clock_i,
   input  logic        nreset_i,
   output logic        im_req_o,
   output logic [31:0] im_addr_o,
   input  logic        im_gnt_i,
   input  logic        im_rvalid_i,
   input  logic [31:0] im_rdata_i,
   output logic [31:0] du_instruct_o,
   output logic [31:0] du_pc_o,
   output logic        du_bubble_o,
   output logic        du_branch_taken_o,
   input  logic        du_stall_i,
   input  logic        xu_branch_flush_i,
   input  logic [31:0] xu_branch_pc_i
);

   localparam int CW  = $clog2(DEPTH + 1);
   localparam int CW1 = CW + 1;

   fetch_state_t  r_state;
   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_resp_pc;
   logic [31:0]   r_last_pc;
   logic [CW-1:0] r_outstanding;
   logic [CW-1:0] r_drop;
   logic          r_redirect;
   logic          r_req;

   fetch_state_t  w_state_next;
   logic [CW-1:0] w_out_next;
   logic [CW-1:0] w_drop_next;
   logic [CW-1:0] w_inflight;
   logic [CW-1:0] w_count;
   logic [CW-1:0] w_count_next;
   logic          w_req_next;
   logic          w_grant;
   logic          w_resp_ok;
   logic          w_drop_hit;
   logic          w_push;
   logic          w_pop;
   logic          w_empty;
   logic [31:0]   w_target;
   logic          w_unused_pc_lsb;
   fetch_entry_t  w_entry;
   fetch_entry_t  w_head;

   assign w_target        = {xu_branch_pc_i[31:2], 2'b00};
   assign w_unused_pc_lsb = ^xu_branch_pc_i[1:0];

   // A response with nothing outstanding is a protocol error and is dropped.
   assign w_grant    = r_req & im_gnt_i;
   assign w_resp_ok  = im_rvalid_i & (r_state != FS_DRAIN) & (r_outstanding != '0);
   assign w_drop_hit = im_rvalid_i & (r_state == FS_DRAIN) & (r_drop != '0);
   assign w_inflight = r_outstanding + CW'(w_grant) - CW'(w_resp_ok);
   assign w_push     = w_resp_ok & ~xu_branch_flush_i;
   assign w_pop      = ~w_empty & ~du_stall_i & ~xu_branch_flush_i;

   assign w_entry = '{instr: im_rdata_i, pc: r_resp_pc, redirect: r_redirect};

   fetch_buffer #(.DEPTH(DEPTH)) u_buffer (
      .clock_i  (clock_i),
      .nreset_i (nreset_i),
      .i_push   (w_push),
      .i_entry  (w_entry),
      .i_pop    (w_pop),
      .i_clear  (xu_branch_flush_i),
      .o_count  (w_count),
      .o_empty  (w_empty),
      .o_head   (w_head)
   );

   assign w_count_next = xu_branch_flush_i ? '0 : (w_count + CW'(w_push) - CW'(w_pop));

   always_comb begin
      w_state_next = r_state;
      w_out_next   = r_outstanding;
      w_drop_next  = r_drop;
      case (r_state)
         FS_DRAIN: begin
            w_out_next  = '0;
            w_drop_next = r_drop - CW'(w_drop_hit);
            if (w_drop_next == '0) w_state_next = FS_RUN;
         end
         default: begin
            w_state_next = FS_RUN;
            w_out_next   = w_inflight;
            w_drop_next  = '0;
            if (xu_branch_flush_i) begin
               w_out_next = '0;
               if (w_inflight != '0) begin
                  w_state_next = FS_DRAIN;
                  w_drop_next  = w_inflight;
               end
            end
         end
      endcase
   end

   // Request is registered from next-cycle counts, so the stall input never reaches im_req_o directly.
   assign w_req_next = (w_state_next == FS_RUN) &&
                       ((CW1'(w_out_next) + CW1'(w_count_next)) < CW1'(DEPTH));

   always_ff @(posedge clock_i or negedge nreset_i) begin
      if (!nreset_i) begin
         r_state       <= FS_BOOT;
         r_fetch_pc    <= PC_INIT;
         r_resp_pc     <= PC_INIT;
         r_last_pc     <= PC_INIT;
         r_outstanding <= '0;
         r_drop        <= '0;
         r_redirect    <= 1'b0;
         r_req         <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_outstanding <= w_out_next;
         r_drop        <= w_drop_next;
         r_req         <= w_req_next;
         if (xu_branch_flush_i) begin
            r_fetch_pc <= w_target;
            r_resp_pc  <= w_target;
            r_redirect <= 1'b1;
         end else begin
            if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;
            if (w_push) begin
               r_resp_pc  <= r_resp_pc + 32'd4;
               r_redirect <= 1'b0;
            end
         end
         if (!w_empty) r_last_pc <= w_head.pc;
      end
   end

   assign im_req_o          = r_req;
   assign im_addr_o         = r_fetch_pc;
   assign du_bubble_o       = w_empty;
   assign du_instruct_o     = w_empty ? `NOP_INSTRUCT : w_head.instr;
   assign du_pc_o           = w_empty ? r_last_pc : w_head.pc;
   assign du_branch_taken_o = ~w_empty & w_head.redirect;

   resp_without_request: assert property (@(posedge clock_i) disable iff (!nreset_i)
      !(im_rvalid_i && (r_state != FS_DRAIN) && (r_outstanding == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model, delivery scoreboard, and hand-timed checks.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clock_i = 1'b0;
   logic        nreset_i = 1'b0;
   logic        im_req_o;
   logic [31:0] im_addr_o;
   logic        im_gnt_i = 1'b0;
   logic        im_rvalid_i = 1'b0;
   logic [31:0] im_rdata_i = '0;
   logic [31:0] du_instruct_o;
   logic [31:0] du_pc_o;
   logic        du_bubble_o;
   logic        du_branch_taken_o;
   logic        du_stall_i = 1'b0;
   logic        xu_branch_flush_i = 1'b0;
   logic [31:0] xu_branch_pc_i = '0;

   fetch_unit #(.PC_INIT(32'h0000_0000), .DEPTH(4)) dut (
      .clock_i           (clock_i),
      .nreset_i          (nreset_i),
      .im_req_o          (im_req_o),
      .im_addr_o         (im_addr_o),
      .im_gnt_i          (im_gnt_i),
      .im_rvalid_i       (im_rvalid_i),
      .im_rdata_i        (im_rdata_i),
      .du_instruct_o     (du_instruct_o),
      .du_pc_o           (du_pc_o),
      .du_bubble_o       (du_bubble_o),
      .du_branch_taken_o (du_branch_taken_o),
      .du_stall_i        (du_stall_i),
      .xu_branch_flush_i (xu_branch_flush_i),
      .xu_branch_pc_i    (xu_branch_pc_i)
   );

   always #5 clock_i = ~clock_i;

   int          n_checks = 0;
   int          n_fail = 0;
   int          n_granted = 0;
   int          n_delivered = 0;
   logic        gnt_en = 1'b0;
   logic        mem_hold = 1'b0;
   logic [31:0] exp_pc = '0;
   logic        exp_taken = 1'b0;
   logic [31:0] pend_q[$];

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return pc ^ 32'h5A5A_0F13;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   // One cycle: memory answers the oldest grant, grants are recorded, pops are scored.
   task automatic tick();
      logic [31:0] a;
      @(negedge clock_i);
      if (!mem_hold && pend_q.size() != 0) begin
         a = pend_q.pop_front();
         im_rvalid_i = 1'b1;
         im_rdata_i  = instr_of(a);
      end else begin
         im_rvalid_i = 1'b0;
         im_rdata_i  = '0;
      end
      im_gnt_i = gnt_en;
      if (im_req_o && im_gnt_i) begin
         pend_q.push_back(im_addr_o);
         n_granted++;
      end
      if (!du_bubble_o && !du_stall_i && !xu_branch_flush_i) begin
         check_eq("dlv_pc", du_pc_o, exp_pc);
         check_eq("dlv_instr", du_instruct_o, instr_of(exp_pc));
         check_eq("dlv_taken", du_branch_taken_o, exp_taken);
         exp_pc    = exp_pc + 32'd4;
         exp_taken = 1'b0;
         n_delivered++;
      end
      @(posedge clock_i);
      #1;
   endtask

   task automatic do_flush(input logic [31:0] pc, input logic [31:0] target);
      xu_branch_flush_i = 1'b1;
      xu_branch_pc_i    = pc;
      exp_pc            = target;
      exp_taken         = 1'b1;
      tick();
      xu_branch_flush_i = 1'b0;
   endtask

   task automatic quiesce(input string tag);
      gnt_en = 1'b0;
      repeat (6) tick();
      check_eq({tag, "_bubble"}, du_bubble_o, 1'b1);
      check_eq({tag, "_nop"}, du_instruct_o, NOP);
      check_eq({tag, "_taken"}, du_branch_taken_o, 1'b0);
      check_eq({tag, "_next_addr"}, im_addr_o, exp_pc);
      check_eq({tag, "_pc_hold"}, du_pc_o, exp_pc - 32'd4);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      repeat (3) @(posedge clock_i);
      #1;
      check_eq("rst_req", im_req_o, 1'b0);
      check_eq("rst_addr", im_addr_o, 32'h0);
      check_eq("rst_instr", du_instruct_o, NOP);
      check_eq("rst_pc", du_pc_o, 32'h0);
      check_eq("rst_bubble", du_bubble_o, 1'b1);
      check_eq("rst_taken", du_branch_taken_o, 1'b0);
      nreset_i = 1'b1;
      check_eq("boot_req", im_req_o, 1'b0);

      // Streaming from reset with always-grant, one-cycle memory
      gnt_en = 1'b1;
      tick();
      check_eq("first_req", im_req_o, 1'b1);
      check_eq("first_addr", im_addr_o, 32'h0);
      tick();
      check_eq("second_addr", im_addr_o, 32'h4);
      tick();
      check_eq("lat_bubble", du_bubble_o, 1'b0);
      check_eq("lat_pc", du_pc_o, 32'h0);
      repeat (5) tick();

      // Decode stall: buffer fills to DEPTH and output freezes on the head
      du_stall_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check_eq("stall_hold_pc", du_pc_o, exp_pc);
      end
      check_eq("stall_fill", 32'(n_granted - n_delivered), 32'd4);
      check_eq("stall_req_off", im_req_o, 1'b0);
      du_stall_i = 1'b0;
      repeat (6) tick();
      quiesce("q_stall");

      // Grant withheld; flush while the request is pending
      do_flush(32'h0, 32'h0);
      check_eq("flush_idle_req", im_req_o, 1'b1);
      check_eq("flush_idle_addr", im_addr_o, 32'h0);
      gnt_en = 1'b1;
      tick();
      tick();
      gnt_en = 1'b0;
      check_eq("nogrant_req_1", im_req_o, 1'b1);
      check_eq("nogrant_addr_1", im_addr_o, 32'h8);
      tick();
      check_eq("nogrant_addr_2", im_addr_o, 32'h8);
      do_flush(32'h200, 32'h200);
      check_eq("flush_pop_addr", im_addr_o, 32'h200);
      check_eq("flush_pop_bubble", du_bubble_o, 1'b1);
      tick();
      check_eq("nogrant_addr_3", im_addr_o, 32'h200);
      check_eq("nogrant_req_3", im_req_o, 1'b1);
      gnt_en = 1'b1;
      repeat (6) tick();

      // Flush coincident with a response, a grant and a pop
      do_flush(32'h300, 32'h300);
      check_eq("flush_rv_bubble", du_bubble_o, 1'b1);
      check_eq("flush_rv_drain", im_req_o, 1'b0);
      tick();
      check_eq("flush_rv_req", im_req_o, 1'b1);
      check_eq("flush_rv_addr", im_addr_o, 32'h300);
      repeat (6) tick();
      quiesce("q_flush_rv");

      // Flush with two requests outstanding: both responses are dropped first
      mem_hold = 1'b1;
      gnt_en   = 1'b1;
      tick();
      tick();
      gnt_en = 1'b0;
      do_flush(32'h103, 32'h100);
      mem_hold = 1'b0;
      check_eq("drain_req_1", im_req_o, 1'b0);
      check_eq("drain_addr", im_addr_o, 32'h100);
      tick();
      check_eq("drain_req_2", im_req_o, 1'b0);
      tick();
      check_eq("drain_done_req", im_req_o, 1'b1);
      check_eq("drain_done_addr", im_addr_o, 32'h100);
      gnt_en = 1'b1;
      repeat (6) tick();
      quiesce("q_drain");

      // Fetch PC wrap-around
      do_flush(32'hFFFF_FFFE, 32'hFFFF_FFFC);
      check_eq("wrap_first_addr", im_addr_o, 32'hFFFF_FFFC);
      gnt_en = 1'b1;
      tick();
      check_eq("wrap_addr", im_addr_o, 32'h0);
      repeat (6) tick();
      quiesce("q_wrap");

      // Reset asserted mid-operation
      gnt_en = 1'b1;
      repeat (3) tick();
      nreset_i = 1'b0;
      pend_q.delete();
      im_rvalid_i = 1'b0;
      #1;
      check_eq("mid_rst_req", im_req_o, 1'b0);
      check_eq("mid_rst_addr", im_addr_o, 32'h0);
      check_eq("mid_rst_bubble", du_bubble_o, 1'b1);
      check_eq("mid_rst_pc", du_pc_o, 32'h0);
      repeat (2) tick();
      nreset_i  = 1'b1;
      exp_pc    = 32'h0;
      exp_taken = 1'b0;
      check_eq("reboot_req", im_req_o, 1'b0);
      tick();
      check_eq("reboot_first_req", im_req_o, 1'b1);
      check_eq("reboot_first_addr", im_addr_o, 32'h0);
      repeat (4) tick();
      quiesce("q_reboot");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage: owns the program counter, issues word reads to instruction memory over a request/grant/response handshake, buffers returned instructions with their PCs, and presents them to decode_unit one per cycle with bubble and branch-target marking. It drives the decode-side fetch interface (instruction, PC, bubble, branch-taken) and obeys decode stall and execution-unit redirect.

## Interface
- PC_INIT, default `PC_INIT: PC value after reset; bits [1:0] must be 0.
- DEPTH, default 4: instruction buffer entries and maximum requests in flight; legal range 2..8.
- clock_i  in  1  clock.
- nreset_i  in  1  reset, asynchronous, active-low.
- im_req_o  out  1  fetch request valid.
- im_addr_o  out  32  byte address of the request, word aligned.
- im_gnt_i  in  1  request accepted this cycle.
- im_rvalid_i  in  1  response valid; responses return in request order.
- im_rdata_i  in  32  instruction word.
- du_instruct_o  out  32  instruction to decode.
- du_pc_o  out  32  PC of du_instruct_o.
- du_bubble_o  out  1  1 = du_instruct_o is not a real instruction.
- du_branch_taken_o  out  1  1 = this instruction is the first one fetched after a redirect.
- du_stall_i  in  1  decode cannot accept this cycle.
- xu_branch_flush_i  in  1  redirect fetch.
- xu_branch_pc_i  in  32  redirect target; bits [1:0] ignored, treated as 0.

## Operation
- FSM states: BOOT (reset state), RUN, DRAIN.
- BOOT -> RUN unconditionally one cycle after reset release; no request in BOOT.
- RUN: im_req_o = 1 when outstanding + occupancy < DEPTH, computed only from registered counts. du_stall_i has no combinational path to im_req_o.
- Handshake: im_addr_o = fetch PC. While im_req_o is high without im_gnt_i, im_addr_o is held stable, except on flush. On req & gnt: fetch PC += 4 (wraps mod 2^32), outstanding += 1.
- Response (im_rvalid_i, outside DRAIN): push {im_rdata_i, PC, redirect flag} into the buffer, outstanding -= 1. The PC for each entry comes from a response-PC counter that advances by 4 per response.
- Output: buffer non-empty -> head entry, du_bubble_o = 0. Buffer empty -> du_instruct_o = `NOP_INSTRUCT, du_bubble_o = 1, du_pc_o holds its last value, du_branch_taken_o = 0.
- Pop the head when du_bubble_o = 0 and du_stall_i = 0. A bubble is never held by a stall.
- Flush (any state): fetch PC and response PC <= {xu_branch_pc_i[31:2], 2'b00}. Buffer cleared. Redirect flag set; it is attached to the next pushed entry, then cleared.
  - If requests are in flight (outstanding > 0 after counting a grant in the flush cycle), go to DRAIN with drop count = that outstanding value.
  - Otherwise stay in or go to RUN.
- DRAIN: im_req_o = 0. Each im_rvalid_i is discarded and decrements the drop count. When the count reaches 0, go to RUN the next cycle.
  - A flush during DRAIN updates the PC only; the drop count is unchanged except for any same-cycle response.
- Simultaneous flush and response: the response is discarded and counted against the drop count.
- Simultaneous flush and pop: the flush wins.
- Simultaneous push and pop: occupancy is unchanged.
- Response arriving with outstanding = 0: protocol error. Ignore it; simulation assertion fires.

## Timing
- Reset values:
  - im_req_o = 0, im_addr_o = PC_INIT
  - du_instruct_o = `NOP_INSTRUCT, du_pc_o = PC_INIT, du_bubble_o = 1, du_branch_taken_o = 0
  - state BOOT, all counts 0
- Reset asserted mid-operation clears everything asynchronously. In-flight memory responses after release are the memory's responsibility; the bench does not drive them.
- First im_req_o: cycle 1 after reset release.
- Latency: grant in cycle N, rvalid in N+1 -> instruction at the du outputs in N+2 (buffer registered, head read combinationally from registered storage).
- Flush in cycle F: im_req_o for the target in F+1 if nothing is outstanding.
- Sustained one instruction per cycle needs DEPTH >= 3 with single-cycle memory.

## Structure
- cpu_core_pkg: fetch_state_t enum {FS_BOOT, FS_RUN, FS_DRAIN}; fetch buffer entry struct {instr, pc, redirect}.
- Reuse existing `PC_INIT and `NOP_INSTRUCT from cpu_core_macros.svh.
- Sub-module fetch_buffer: synchronous FIFO of DEPTH entries with push, pop, clear, count, and head outputs. Clear takes priority over push.

## Test plan
- Reset with PC_INIT = 0x0: after release, requests to 0x0, 0x4, 0x8 with always-grant and 1-cycle response -> decode sees PCs 0x0/0x4/0x8 in order, bubble 0, branch_taken 0.
- Hold du_stall_i = 1 for 10 cycles -> at most DEPTH (4) grants in flight plus buffered; du outputs frozen on the head; releasing the stall drains in order with no loss.
- Flush to 0x103 with 2 requests outstanding -> next request addr 0x100 only after 2 discarded responses; first delivered instruction has pc 0x100 and du_branch_taken_o = 1, the next has 0.
- Withhold im_gnt_i for 3 cycles -> im_addr_o stable at 0x8 and im_req_o high; a flush in cycle 2 changes im_addr_o to the target the next cycle.
- Flush coincident with rvalid and with a pop -> no stale instruction delivered, no double pop, buffer empty, du_bubble_o = 1.
- Fetch PC 0xFFFFFFFC granted -> next request addr 0x00000000.
